// File: rtl/reset_seq_pkg.sv
// Shared types and default timing for the chip reset sequencer.
package reset_seq_pkg;

  // Sequencer states. The encoding is visible on state_o, so it is fixed here.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADC_HOLD  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_DSP_HOLD  = 3'd3,
    ST_CORE_HOLD = 3'd4,
    ST_RUN       = 3'd5,
    ST_PASS      = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  // Reason latched on entry to FAIL.
  typedef enum logic [1:0] {
    FR_NONE          = 2'd0,
    FR_LOCK          = 2'd1,
    FR_CYCLE_TIMEOUT = 2'd2,
    FR_ABORT         = 2'd3
  } fail_reason_t;

  // Default hold / timeout lengths in core_clock cycles.
  localparam int unsigned DEF_ADC_DLY     = 48;
  localparam int unsigned DEF_DSP_DLY     = 16;
  localparam int unsigned DEF_CORE_DLY    = 16;
  localparam int unsigned DEF_LOCK_TO     = 1024;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 64;

  // Width of the shared hold/timeout down-counter.
  localparam int unsigned DLY_CNT_W = 32;

  // States in which abort forces FAIL (abort is ignored in IDLE, PASS, FAIL).
  function automatic logic abort_applies(state_t s);
    return (s inside {ST_ADC_HOLD, ST_WAIT_LOCK, ST_DSP_HOLD, ST_CORE_HOLD, ST_RUN});
  endfunction

endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// Multi-flop synchronizer bringing the asynchronous adc_lock into core_clock.
module bit_sync
  import reset_seq_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic core_clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;

  // Each stage takes the previous one; stage 0 takes the raw input.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_next[gi] = d;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Shift chain, cleared to 0 so lock is never assumed out of reset.
  always_ff @(posedge core_clock) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases ADC, DSP and core resets in order, then watches the run phase
// and latches pass/fail with a reason code.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned ADC_DLY     = DEF_ADC_DLY,
  parameter int unsigned DSP_DLY     = DEF_DSP_DLY,
  parameter int unsigned CORE_DLY    = DEF_CORE_DLY,
  parameter int unsigned LOCK_TO     = DEF_LOCK_TO,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             core_clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             adc_lock,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic             success_in,
  output logic             adc_reset_o,
  output logic             dsp_reset_o,
  output logic             core_reset_o,
  output logic             running,
  output logic             done,
  output logic             fail,
  output logic [1:0]       fail_reason,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_reg, state_next;
  fail_reason_t           reason_reg, reason_next;
  logic [DLY_CNT_W-1:0]   dly_cnt_reg, dly_cnt_next;
  logic [CNT_W-1:0]       cycle_cnt_reg, cycle_cnt_next;
  logic                   lock_s;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .core_clock (core_clock),
    .reset      (reset),
    .d          (adc_lock),
    .q          (lock_s)
  );

  // State, delay counter, reason and run-cycle counter registers.
  always_ff @(posedge core_clock) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      reason_reg    <= FR_NONE;
      dly_cnt_reg   <= '0;
      cycle_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      reason_reg    <= reason_next;
      dly_cnt_reg   <= dly_cnt_next;
      cycle_cnt_reg <= cycle_cnt_next;
    end
  end

  // Next-state logic: hold states count down from a value loaded on entry;
  // abort outranks everything while sequencing or running.
  always_comb begin
    state_next     = state_reg;
    reason_next    = reason_reg;
    cycle_cnt_next = cycle_cnt_reg;
    dly_cnt_next   = (dly_cnt_reg != '0) ? dly_cnt_reg - DLY_CNT_W'(1) : '0;

    if (abort && abort_applies(state_reg)) begin
      state_next  = ST_FAIL;
      reason_next = FR_ABORT;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !abort) begin
            state_next   = ST_ADC_HOLD;
            dly_cnt_next = DLY_CNT_W'(ADC_DLY);
          end
        end
        ST_ADC_HOLD: begin
          if (dly_cnt_reg == '0) begin
            state_next   = ST_WAIT_LOCK;
            dly_cnt_next = DLY_CNT_W'(LOCK_TO);
          end
        end
        ST_WAIT_LOCK: begin
          // Lock seen on the final timeout cycle still counts as success.
          if (lock_s) begin
            state_next   = ST_DSP_HOLD;
            dly_cnt_next = DLY_CNT_W'(DSP_DLY);
          end else if (dly_cnt_reg == '0) begin
            state_next  = ST_FAIL;
            reason_next = FR_LOCK;
          end
        end
        ST_DSP_HOLD: begin
          if (dly_cnt_reg == '0) begin
            state_next   = ST_CORE_HOLD;
            dly_cnt_next = DLY_CNT_W'(CORE_DLY);
          end
        end
        ST_CORE_HOLD: begin
          if (dly_cnt_reg == '0) begin
            state_next     = ST_RUN;
            cycle_cnt_next = '0;
          end
        end
        ST_RUN: begin
          // The counter only advances while staying in RUN, so it freezes
          // at the value that caused the exit.
          if (!lock_s) begin
            state_next  = ST_FAIL;
            reason_next = FR_LOCK;
          end else if (success_in) begin
            state_next = ST_PASS;
          end else if ((max_cycles != '0) && (cycle_cnt_reg >= max_cycles)) begin
            state_next  = ST_FAIL;
            reason_next = FR_CYCLE_TIMEOUT;
          end else if (cycle_cnt_reg != '1) begin
            cycle_cnt_next = cycle_cnt_reg + CNT_ONE;
          end
        end
        ST_PASS, ST_FAIL: begin
          if (start && !abort) begin
            state_next     = ST_ADC_HOLD;
            dly_cnt_next   = DLY_CNT_W'(ADC_DLY);
            reason_next    = FR_NONE;
            cycle_cnt_next = '0;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Moore decode of the pins and status from the registered state.
  always_comb begin
    adc_reset_o  = 1'b1;
    dsp_reset_o  = 1'b1;
    core_reset_o = 1'b1;
    running      = 1'b0;
    done         = 1'b0;
    fail         = 1'b0;
    adc_reset_o  = (state_reg inside {ST_IDLE, ST_ADC_HOLD, ST_FAIL});
    dsp_reset_o  = !(state_reg inside {ST_CORE_HOLD, ST_RUN, ST_PASS});
    core_reset_o = !(state_reg inside {ST_RUN, ST_PASS});
    running      = (state_reg == ST_RUN);
    done         = (state_reg inside {ST_PASS, ST_FAIL});
    fail         = (state_reg == ST_FAIL);
  end

  assign fail_reason = reason_reg;
  assign state_o     = state_reg;
  assign cycle_count = cycle_cnt_reg;

endmodule
